traffic_cmd_deser: RTL and testbench
====================================

# traffic_cmd_deser

Byte-stream command deserializer that sits directly upstream of the traffic-light controller and drives its `cmd_type_i` / `cmd_valid_i` / `cmd_data_i` bus. It accepts framed command bytes over a valid/ready handshake and validates header, command type and duration range. Each accepted command is emitted as a single-cycle pulse; malformed or stalled frames are dropped and reported on an error strobe.

## Interface
- `DATA_WIDTH`, 16: duration width in ms. Must be a multiple of 8. `NBYTES = DATA_WIDTH/8`.
- `CLK_I_FREQ`, 2_000_000: clock frequency in Hz.
- `TIMEOUT_MS`, 10: maximum gap between payload bytes. `TIMEOUT_CYC = TIMEOUT_MS*CLK_I_FREQ/1000`.
- `MAX_TIME_MS`, 60000: largest legal duration. Must be ≤ 2^DATA_WIDTH−1.
- `clk_i`, in, 1: single clock.
- `srst_i`, in, 1: reset; asynchronous, active-low.
- `rx_data_i`, in, 8: incoming byte.
- `rx_valid_i`, in, 1: byte valid.
- `rx_ready_o`, out, 1: block can accept a byte.
- `cmd_type_o`, out, 3: command code to the controller.
- `cmd_data_o`, out, DATA_WIDTH: duration in ms.
- `cmd_valid_o`, out, 1: one-cycle command strobe.
- `err_o`, out, 1: one-cycle error strobe.
- `err_code_o`, out, 2: error cause; meaningful only while `err_o`=1. 0 TIMEOUT, 1 BAD_HDR, 2 BAD_TYPE, 3 RANGE.
- `busy_o`, out, 1: high while a frame is partially received.

## Operation
- A byte is accepted on a rising edge where `rx_valid_i & rx_ready_o`.
- Header byte: bits [7:3] must equal 5'b10101; bits [2:0] are the type.
  - Type codes: 0 OFF, 1 STD, 2 YEL_BLN, 3 SET_GRN, 4 SET_RED, 5 SET_YEL.
- Types 0–2 carry no payload and are emitted directly with `cmd_data_o`=0.
- Types 3–5 are followed by NBYTES payload bytes, LSB first. They are assembled into a DATA_WIDTH shift/capture register.
- FSM states:
  - IDLE: `rx_ready_o`=1. On header:
    - bad pattern → err BAD_HDR, stay IDLE.
    - type 6/7 → err BAD_TYPE, stay IDLE.
    - type 0–2 → EMIT.
    - type 3–5 → PAYLOAD with byte count 0.
  - PAYLOAD: `rx_ready_o`=1, `busy_o`=1. Each accepted byte is stored and increments the count. On byte NBYTES:
    - value 0 or > MAX_TIME_MS → err RANGE, go to IDLE.
    - otherwise → EMIT.
  - EMIT: one cycle. `cmd_valid_o`=1, `rx_ready_o`=0. Next state is IDLE unconditionally.
- Timeout counter:
  - Cleared on entry to PAYLOAD and on every accepted byte.
  - Increments each PAYLOAD cycle without acceptance.
  - Reaching TIMEOUT_CYC → err TIMEOUT, partial frame discarded, go to IDLE.
  - If a byte is accepted in the same cycle the count would expire, the byte wins and the counter clears.
- `cmd_type_o` / `cmd_data_o` update only when entering EMIT and hold until the next emitted command. Error frames never change them.
- At most one of `cmd_valid_o` / `err_o` is high in any cycle.
- Reset mid-frame: partial data is discarded immediately and the FSM returns to IDLE. No strobe is produced.

## Timing
- All outputs are registered.
- Reset values: `rx_ready_o`=0, `cmd_valid_o`=0, `err_o`=0, `err_code_o`=0, `cmd_type_o`=0, `cmd_data_o`=0, `busy_o`=0, FSM=IDLE.
- `rx_ready_o` rises on the first clock edge after `srst_i` is released.
- Mode command: header accepted at edge N → `cmd_valid_o` high for cycle N+1. `rx_ready_o` is low in that cycle; the next byte can be accepted at edge N+2.
- Set command: last payload byte accepted at edge M → `cmd_valid_o` high for cycle M+1.
- Error: offending byte accepted at edge N → `err_o` high for cycle N+1. `rx_ready_o` stays 1, so back-to-back headers are accepted.
- Timeout: `err_o` asserts TIMEOUT_CYC cycles after the last accepted byte.
- Sustained throughput: one mode command per 2 cycles; one set command per NBYTES+2 cycles.

## Test plan
- Defaults, send 0xA9 → one cycle later `cmd_valid_o`=1, `cmd_type_o`=1, `cmd_data_o`=0. `rx_ready_o`=0 in that cycle only.
- Send 0xAC, 0xE8, 0x03 back-to-back → `cmd_valid_o` one cycle after 0x03, with type 4, data 1000. `busy_o`=1 only between the header and the last byte.
- Send 0xAE → `err_o`=1, code 2. Send 0x29 → `err_o`=1, code 1. Neither produces `cmd_valid_o`, and `cmd_type_o` keeps its previous value.
- Send 0xAB, 0x00, 0x00 → code 3. Send 0xAD, 0x61, 0xEA (60001) → code 3. Send 0xAD, 0x60, 0xEA (60000) → emitted with type 5, data 60000.
- Send 0xAB, 0x10, then idle 20000 cycles → `err_o` code 0 exactly 20000 cycles after 0x10. Then 0xA8 → type 0 emitted. Repeat with the second byte arriving on cycle 20000 → no error, command emitted.
- Send 0xAC, 0x05, assert `srst_i`=0 asynchronously mid-cycle → outputs clear immediately. After release, send 0xA9 → type 1 emitted, no stale payload.

Source files
------------

// File: rtl/traffic_cmd_deser_if.sv
// Byte-stream receive side and command/error output bus of the traffic-light command deserializer.
interface traffic_cmd_deser_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic [7:0]            rx_data_i;
    logic                  rx_valid_i;
    logic                  rx_ready_o;
    logic [2:0]            cmd_type_o;
    logic [DATA_WIDTH-1:0] cmd_data_o;
    logic                  cmd_valid_o;
    logic                  err_o;
    logic [1:0]            err_code_o;
    logic                  busy_o;

    modport slave (
        input  rx_data_i, rx_valid_i,
        output rx_ready_o, cmd_type_o, cmd_data_o, cmd_valid_o, err_o, err_code_o, busy_o
    );

    modport master (
        output rx_data_i, rx_valid_i,
        input  rx_ready_o, cmd_type_o, cmd_data_o, cmd_valid_o, err_o, err_code_o, busy_o
    );
endinterface

// File: rtl/traffic_cmd_deser.sv
// Framed command deserializer: validates header/type/duration, emits one-cycle command or error strobes.
module traffic_cmd_deser #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned CLK_I_FREQ  = 2_000_000,
    parameter int unsigned TIMEOUT_MS  = 10,
    parameter int unsigned MAX_TIME_MS = 60000
) (
    input  logic                 clk_i,
    input  logic                 srst_i,
    traffic_cmd_deser_if.slave   bus
);

    localparam int unsigned NBYTES      = DATA_WIDTH / 8;
    localparam int unsigned TIMEOUT_CYC = TIMEOUT_MS * CLK_I_FREQ / 1000;
    localparam int unsigned BC_W        = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned TO_W        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [1:0] ERR_TIMEOUT  = 2'd0;
    localparam logic [1:0] ERR_BAD_HDR  = 2'd1;
    localparam logic [1:0] ERR_BAD_TYPE = 2'd2;
    localparam logic [1:0] ERR_RANGE    = 2'd3;

    typedef enum logic [1:0] {IDLE, PAYLOAD, EMIT} state_t;

    state_t                state_q, state_d;
    logic [BC_W-1:0]       bcnt_q, bcnt_d;
    logic [TO_W-1:0]       tmo_q, tmo_d;
    logic [DATA_WIDTH-1:0] pay_q, pay_d;
    logic [2:0]            ptype_q, ptype_d;
    logic [2:0]            cmd_type_q, cmd_type_d;
    logic [DATA_WIDTH-1:0] cmd_data_q, cmd_data_d;
    logic [1:0]            err_code_q, err_code_d;
    logic                  err_d;
    logic                  err_q, cmd_valid_q, ready_q, busy_q;

    logic                  acc;
    logic                  hdr_ok;
    logic [2:0]            hdr_type;

    assign acc      = bus.rx_valid_i & ready_q;
    assign hdr_ok   = (bus.rx_data_i[7:3] == 5'b10101);
    assign hdr_type = bus.rx_data_i[2:0];

    // Next-state, payload capture and strobe generation
    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        tmo_d      = tmo_q;
        pay_d      = pay_q;
        ptype_d    = ptype_q;
        cmd_type_d = cmd_type_q;
        cmd_data_d = cmd_data_q;
        err_code_d = err_code_q;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (acc) begin
                    if (!hdr_ok) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_BAD_HDR;
                    end else if (hdr_type > 3'd5) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_BAD_TYPE;
                    end else if (hdr_type <= 3'd2) begin
                        state_d    = EMIT;
                        cmd_type_d = hdr_type;
                        cmd_data_d = '0;
                    end else begin
                        state_d = PAYLOAD;
                        ptype_d = hdr_type;
                        bcnt_d  = '0;
                        tmo_d   = '0;
                    end
                end
            end

            PAYLOAD: begin
                if (acc) begin
                    tmo_d = '0;
                    for (int i = 0; i < int'(NBYTES); i++) begin
                        if (bcnt_q == BC_W'(i)) pay_d[8*i +: 8] = bus.rx_data_i;
                    end
                    if (bcnt_q == BC_W'(NBYTES - 1)) begin
                        if (pay_d == '0 || pay_d > DATA_WIDTH'(MAX_TIME_MS)) begin
                            state_d    = IDLE;
                            err_d      = 1'b1;
                            err_code_d = ERR_RANGE;
                        end else begin
                            state_d    = EMIT;
                            cmd_type_d = ptype_q;
                            cmd_data_d = pay_d;
                        end
                    end else begin
                        bcnt_d = bcnt_q + BC_W'(1);
                    end
                end else if (tmo_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    // A byte arriving on the expiring cycle takes priority (handled above)
                    state_d    = IDLE;
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + TO_W'(1);
                end
            end

            EMIT: state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk_i or negedge srst_i) begin
        if (!srst_i) begin
            state_q     <= IDLE;
            bcnt_q      <= '0;
            tmo_q       <= '0;
            pay_q       <= '0;
            ptype_q     <= '0;
            cmd_type_q  <= '0;
            cmd_data_q  <= '0;
            err_code_q  <= '0;
            err_q       <= 1'b0;
            cmd_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            tmo_q       <= tmo_d;
            pay_q       <= pay_d;
            ptype_q     <= ptype_d;
            cmd_type_q  <= cmd_type_d;
            cmd_data_q  <= cmd_data_d;
            err_code_q  <= err_code_d;
            err_q       <= err_d;
            cmd_valid_q <= (state_d == EMIT);
            ready_q     <= (state_d != EMIT);
            busy_q      <= (state_d == PAYLOAD);
        end
    end

    assign bus.rx_ready_o  = ready_q;
    assign bus.cmd_type_o  = cmd_type_q;
    assign bus.cmd_data_o  = cmd_data_q;
    assign bus.cmd_valid_o = cmd_valid_q;
    assign bus.err_o       = err_q;
    assign bus.err_code_o  = err_code_q;
    assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_traffic_cmd_deser.sv
// Directed bench for traffic_cmd_deser with immediate-assertion checks sampled 1ns after each rising edge.
module tb_traffic_cmd_deser;

    localparam int unsigned DW = 16;
    localparam int unsigned TO = 20000;

    logic clk_i  = 1'b0;
    logic srst_i = 1'b0;
    int   n_checks = 0;
    int   n_fails  = 0;
    logic saw_err;
    logic saw_valid;

    traffic_cmd_deser_if #(.DATA_WIDTH(DW)) bus ();

    traffic_cmd_deser #(
        .DATA_WIDTH (DW),
        .CLK_I_FREQ (2_000_000),
        .TIMEOUT_MS (10),
        .MAX_TIME_MS(60000)
    ) dut (
        .clk_i (clk_i),
        .srst_i(srst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [7:0] b);
        bus.rx_data_i  = b;
        bus.rx_valid_i = 1'b1;
    endtask

    task automatic idle();
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = 8'h00;
    endtask

    initial begin
        idle();
        // Reset state
        step();
        step();
        chk("rst_ready", 32'(bus.rx_ready_o), 0);
        chk("rst_valid", 32'(bus.cmd_valid_o), 0);
        chk("rst_err", 32'(bus.err_o), 0);
        chk("rst_code", 32'(bus.err_code_o), 0);
        chk("rst_type", 32'(bus.cmd_type_o), 0);
        chk("rst_data", 32'(bus.cmd_data_o), 0);
        chk("rst_busy", 32'(bus.busy_o), 0);
        #2 srst_i = 1'b1;
        step();
        chk("ready_after_rst", 32'(bus.rx_ready_o), 1);

        // Mode command STD
        drive(8'hA9); step(); idle();
        chk("std_valid", 32'(bus.cmd_valid_o), 1);
        chk("std_type", 32'(bus.cmd_type_o), 1);
        chk("std_data", 32'(bus.cmd_data_o), 0);
        chk("std_ready_low", 32'(bus.rx_ready_o), 0);
        chk("std_err", 32'(bus.err_o), 0);
        step();
        chk("std_valid_drop", 32'(bus.cmd_valid_o), 0);
        chk("std_ready_back", 32'(bus.rx_ready_o), 1);

        // SET_RED 1000 back-to-back
        drive(8'hAC); step();
        chk("red_busy1", 32'(bus.busy_o), 1);
        chk("red_novalid1", 32'(bus.cmd_valid_o), 0);
        drive(8'hE8); step();
        chk("red_busy2", 32'(bus.busy_o), 1);
        drive(8'h03); step(); idle();
        chk("red_valid", 32'(bus.cmd_valid_o), 1);
        chk("red_type", 32'(bus.cmd_type_o), 4);
        chk("red_data", 32'(bus.cmd_data_o), 1000);
        chk("red_busy_done", 32'(bus.busy_o), 0);
        step();
        chk("red_valid_drop", 32'(bus.cmd_valid_o), 0);

        // Bad type then bad header, back-to-back
        drive(8'hAE); step();
        chk("btype_err", 32'(bus.err_o), 1);
        chk("btype_code", 32'(bus.err_code_o), 2);
        chk("btype_novalid", 32'(bus.cmd_valid_o), 0);
        chk("btype_ready", 32'(bus.rx_ready_o), 1);
        chk("btype_keep_type", 32'(bus.cmd_type_o), 4);
        drive(8'h29); step(); idle();
        chk("bhdr_err", 32'(bus.err_o), 1);
        chk("bhdr_code", 32'(bus.err_code_o), 1);
        chk("bhdr_novalid", 32'(bus.cmd_valid_o), 0);
        chk("bhdr_keep_type", 32'(bus.cmd_type_o), 4);
        step();
        chk("bhdr_err_drop", 32'(bus.err_o), 0);

        // Range: zero
        drive(8'hAB); step();
        drive(8'h00); step();
        drive(8'h00); step(); idle();
        chk("zero_err", 32'(bus.err_o), 1);
        chk("zero_code", 32'(bus.err_code_o), 3);
        chk("zero_novalid", 32'(bus.cmd_valid_o), 0);
        chk("zero_keep_data", 32'(bus.cmd_data_o), 1000);
        step();

        // Range: 60001
        drive(8'hAD); step();
        drive(8'h61); step();
        drive(8'hEA); step(); idle();
        chk("over_err", 32'(bus.err_o), 1);
        chk("over_code", 32'(bus.err_code_o), 3);
        chk("over_keep_type", 32'(bus.cmd_type_o), 4);
        step();

        // Range: 60000 legal
        drive(8'hAD); step();
        drive(8'h60); step();
        drive(8'hEA); step(); idle();
        chk("max_valid", 32'(bus.cmd_valid_o), 1);
        chk("max_err", 32'(bus.err_o), 0);
        chk("max_type", 32'(bus.cmd_type_o), 5);
        chk("max_data", 32'(bus.cmd_data_o), 60000);
        step();

        // Timeout after 20000 idle cycles
        drive(8'hAB); step();
        drive(8'h10); step(); idle();
        saw_err = 1'b0;
        for (int i = 1; i < int'(TO); i++) begin
            step();
            saw_err |= bus.err_o;
        end
        chk("to_no_early_err", 32'(saw_err), 0);
        chk("to_busy_before", 32'(bus.busy_o), 1);
        step();
        chk("to_err", 32'(bus.err_o), 1);
        chk("to_code", 32'(bus.err_code_o), 0);
        chk("to_busy_cleared", 32'(bus.busy_o), 0);
        chk("to_ready", 32'(bus.rx_ready_o), 1);
        step();
        chk("to_err_drop", 32'(bus.err_o), 0);
        drive(8'hA8); step(); idle();
        chk("off_valid", 32'(bus.cmd_valid_o), 1);
        chk("off_type", 32'(bus.cmd_type_o), 0);
        chk("off_data", 32'(bus.cmd_data_o), 0);
        step();

        // Byte arriving exactly on the expiring cycle wins
        drive(8'hAB); step();
        drive(8'h10); step(); idle();
        saw_err = 1'b0;
        saw_valid = 1'b0;
        for (int i = 1; i < int'(TO); i++) begin
            step();
            saw_err   |= bus.err_o;
            saw_valid |= bus.cmd_valid_o;
        end
        chk("edge_no_err_wait", 32'(saw_err | saw_valid), 0);
        drive(8'h10); step(); idle();
        chk("edge_err", 32'(bus.err_o), 0);
        chk("edge_valid", 32'(bus.cmd_valid_o), 1);
        chk("edge_type", 32'(bus.cmd_type_o), 3);
        chk("edge_data", 32'(bus.cmd_data_o), 32'h1010);
        step();

        // Asynchronous reset mid-frame
        drive(8'hAC); step();
        drive(8'h05); step(); idle();
        chk("pre_rst_busy", 32'(bus.busy_o), 1);
        #2 srst_i = 1'b0;
        #1;
        chk("arst_ready", 32'(bus.rx_ready_o), 0);
        chk("arst_busy", 32'(bus.busy_o), 0);
        chk("arst_type", 32'(bus.cmd_type_o), 0);
        chk("arst_data", 32'(bus.cmd_data_o), 0);
        chk("arst_valid", 32'(bus.cmd_valid_o), 0);
        #1 srst_i = 1'b1;
        step();
        chk("post_rst_ready", 32'(bus.rx_ready_o), 1);
        chk("post_rst_busy", 32'(bus.busy_o), 0);
        chk("post_rst_nostrobe", 32'(bus.cmd_valid_o | bus.err_o), 0);
        drive(8'hA9); step(); idle();
        chk("post_std_valid", 32'(bus.cmd_valid_o), 1);
        chk("post_std_type", 32'(bus.cmd_type_o), 1);
        chk("post_std_data", 32'(bus.cmd_data_o), 0);
        chk("post_std_err", 32'(bus.err_o), 0);
        step();
        chk("post_std_drop", 32'(bus.cmd_valid_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
